// File: rtl/vga_capture_pkg.sv
// rtl/vga_capture_pkg.sv - shared VGA 800x600@60 timing defaults and capture FSM states
// Purpose: timing defaults reused by the display timing side, capture window
//          defaults and the capture state encoding.
// Ports:   none (package).
package vga_capture_pkg;

  // 40 MHz pixel clock, 1056 x 628 total, counted from the sync rising edges
  localparam int VGA_H_TOTAL = 1056;
  localparam int VGA_H_BACK  = 88;
  localparam int VGA_V_TOTAL = 628;
  localparam int VGA_V_BACK  = 23;

  localparam int CAP_X_SIZE  = 128;
  localparam int CAP_Y_SIZE  = 96;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/vga_sync_check.sv
// rtl/vga_sync_check.sv - input registers, sync edge detect, line/frame counters and lock check
// Purpose: registers the video pins once, finds HSYNC/VSYNC rising edges,
//          counts clocks per line and lines per frame, flags length mismatches.
// Ports:   clk, rst      - pixel clock, synchronous active-high reset
//          hsync, vsync  - raw active-low syncs
//          data_in       - raw pixel bus
//          s_data        - registered pixel bus
//          v_rise        - VSYNC rising edge seen this cycle
//          h_pos, v_pos  - column/line of the pixel currently in s_data
//          chk_err       - mismatch detected this cycle (combinational)
//          err           - registered 1-clk mismatch pulse
//          locked        - timing matches the parameters
module vga_sync_check
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  data_in,
  output logic [7:0]  s_data,
  output logic        v_rise,
  output logic [15:0] h_pos,
  output logic [15:0] v_pos,
  output logic        chk_err,
  output logic        err,
  output logic        locked
);

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

  logic        s_hsync, s_vsync, hs_d, vs_d;
  logic        h_rise;
  logic        h_ref, v_ref, err_seen;
  logic        line_err, frame_err;
  logic [15:0] h_cnt, v_cnt;

  assign h_rise = s_hsync & ~hs_d;
  assign v_rise = s_vsync & ~vs_d;

  // h_pos/v_pos are the counter values being loaded this cycle, so they line
  // up with the pixel in s_data (the rise cycle carries column 0).
  assign h_pos = h_rise ? 16'd0 : ((h_cnt == 16'hFFFF) ? h_cnt : h_cnt + 16'd1);
  assign v_pos = v_rise ? 16'd0 : (h_rise ? v_cnt + 16'd1 : v_cnt);

  // No reference edge yet after reset: the first line/frame is not judged.
  assign line_err  = h_rise & h_ref & (h_cnt != H_LAST);
  assign frame_err = v_rise & v_ref & (v_cnt != V_LAST);
  assign chk_err   = line_err | frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Syncs idle high; resetting them high avoids a false rise after reset.
      s_hsync  <= 1'b1;
      s_vsync  <= 1'b1;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
      s_data   <= 8'd0;
      h_cnt    <= 16'd0;
      v_cnt    <= 16'd0;
      h_ref    <= 1'b0;
      v_ref    <= 1'b0;
      err_seen <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
    end else begin
      s_hsync <= hsync;
      s_vsync <= vsync;
      hs_d    <= s_hsync;
      vs_d    <= s_vsync;
      s_data  <= data_in;
      h_cnt   <= h_pos;
      v_cnt   <= v_pos;
      h_ref   <= h_ref | h_rise;
      v_ref   <= v_ref | v_rise;
      err     <= chk_err;

      if (v_rise)
        err_seen <= 1'b0;
      else if (line_err)
        err_seen <= 1'b1;

      // Lock only when a whole frame, bounded by two VSYNC rises, was clean.
      if (chk_err)
        locked <= 1'b0;
      else if (v_rise && v_ref && !err_seen)
        locked <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive side: lock to timing and capture a top-left window to RAM
// Purpose: writes the X_SIZE x Y_SIZE top-left window of each enabled frame
//          into a 16-bit-address pixel RAM port.
// Ports:   clk_40m, rst          - pixel clock, synchronous active-high reset
//          hsync, vsync, data_in - video input pins
//          cap_en                - capture enable, sampled at the VSYNC rise
//          wr_en, wr_addr, wr_data - frame-buffer write port
//          frame_done            - 1-clk pulse after the last window pixel
//          locked, err           - timing lock status and mismatch pulse
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int V_BACK  = VGA_V_BACK,
  parameter int X_SIZE  = CAP_X_SIZE,
  parameter int Y_SIZE  = CAP_Y_SIZE
) (
  input  logic        clk_40m,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  data_in,
  input  logic        cap_en,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic        err
);

  localparam logic [15:0] HB = 16'(H_BACK);
  localparam logic [15:0] VB = 16'(V_BACK);
  localparam logic [15:0] XS = 16'(X_SIZE);
  localparam logic [15:0] YS = 16'(Y_SIZE);
  localparam int          XB = $clog2(X_SIZE);

  logic [7:0]  s_data;
  logic        v_rise, chk_err;
  logic [15:0] h_pos, v_pos;
  logic [15:0] x, y, addr;
  logic        in_win, last_pix, wr_last;
  cap_state_t  state, state_nxt;

  vga_sync_check #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_sync (
    .clk     (clk_40m),
    .rst     (rst),
    .hsync   (hsync),
    .vsync   (vsync),
    .data_in (data_in),
    .s_data  (s_data),
    .v_rise  (v_rise),
    .h_pos   (h_pos),
    .v_pos   (v_pos),
    .chk_err (chk_err),
    .err     (err),
    .locked  (locked)
  );

  assign x        = h_pos - HB;
  assign y        = v_pos - VB;
  assign addr     = (y << XB) + x;
  assign in_win   = (state == CAPTURE) && !chk_err &&
                    (h_pos >= HB) && (h_pos < HB + XS) &&
                    (v_pos >= VB) && (v_pos < VB + YS);
  assign last_pix = (x == XS - 16'd1) && (y == YS - 16'd1);

  always_ff @(posedge clk_40m) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A mismatch at the same VSYNC rise must not arm this frame.
      IDLE:    if (v_rise && locked && cap_en && !chk_err) state_nxt = ARMED;
      ARMED:   if (chk_err) state_nxt = IDLE;
               else if (v_pos == VB) state_nxt = CAPTURE;
      CAPTURE: if (chk_err) state_nxt = IDLE;
               else if (wr_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_done = (state == DONE);

  // Output register: write port changes as a unit and is zero when idle.
  always_ff @(posedge clk_40m) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= 16'd0;
      wr_data <= 8'd0;
      wr_last <= 1'b0;
    end else begin
      wr_en   <= in_win;
      wr_addr <= in_win ? addr : 16'd0;
      wr_data <= in_win ? s_data : 8'd0;
      wr_last <= in_win && last_pix;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed self-checking bench for vga_capture on a reduced raster
module tb_vga_capture;

  localparam int H_T  = 40;
  localparam int H_B  = 8;
  localparam int V_T  = 20;
  localparam int V_B  = 4;
  localparam int X_S  = 8;
  localparam int Y_S  = 6;
  localparam int HS_W = 4;
  localparam int VS_W = 2;
  localparam int N_PIX = X_S * Y_S;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, cap_en;
  logic [7:0]  data_in;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done, locked, err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vga_capture #(
    .H_TOTAL (H_T),
    .H_BACK  (H_B),
    .V_TOTAL (V_T),
    .V_BACK  (V_B),
    .X_SIZE  (X_S),
    .Y_SIZE  (Y_S)
  ) dut (
    .clk_40m    (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .data_in    (data_in),
    .cap_en     (cap_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .locked     (locked),
    .err        (err)
  );

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt, first_addr, last_addr, first_wr_cyc, last_wr_cyc;
  int fd_cnt, fd_cyc, err_cnt, err_cyc, lock_cyc, bad_data, bad_idle;
  int start_cyc, pix0_cyc;
  logic prev_locked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Source pixel is column ^ line, so the window pixel at address a is known.
  function automatic logic [7:0] model(input logic [15:0] a);
    int px, py;
    px = int'(a) % X_S;
    py = int'(a) / X_S;
    return 8'((px + H_B) ^ (py + V_B));
  endfunction

  task automatic clear_stats();
    wr_cnt = 0; first_addr = -1; last_addr = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    fd_cnt = 0; fd_cyc = -1; err_cnt = 0; err_cyc = -1; lock_cyc = -1;
    bad_data = 0; bad_idle = 0;
  endtask

  task automatic sample();
    if (wr_en) begin
      if (wr_cnt == 0) begin
        first_addr   = int'(wr_addr);
        first_wr_cyc = cyc;
      end
      wr_cnt++;
      last_addr   = int'(wr_addr);
      last_wr_cyc = cyc;
      if (wr_data !== model(wr_addr)) bad_data++;
    end else if (wr_addr !== 16'd0 || wr_data !== 8'd0) begin
      bad_idle++;
    end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (locked && !prev_locked) lock_cyc = cyc;
    prev_locked = locked;
  endtask

  // One frame; HSYNC/VSYNC rise at column 0 of line 0. cap_pulse raises
  // cap_en only for the clock in which the DUT sees the registered VSYNC rise.
  task automatic run_frame(input int n_lines, input int short_line, input bit cap_pulse,
                           input int rst_line, input int rst_px);
    int len;
    for (int sy = 0; sy < n_lines; sy++) begin
      len = (sy == short_line) ? H_T - 1 : H_T;
      for (int sx = 0; sx < len; sx++) begin
        @(negedge clk);
        sample();
        if (rst) begin
          check("outputs_zero_after_rst", {4'b0, wr_en, wr_addr, wr_data, frame_done, locked, err}, 0);
          rst = 1'b0;
        end
        if (sy == 0 && sx == 0) start_cyc = cyc;
        if (sy == V_B && sx == H_B) pix0_cyc = cyc;
        hsync   = (sx >= len - HS_W) ? 1'b0 : 1'b1;
        vsync   = (sy >= n_lines - VS_W) ? 1'b0 : 1'b1;
        data_in = 8'(sx ^ sy);
        if (cap_pulse) cap_en = (sy == 0 && sx == 1);
        if (sy == rst_line && sx == rst_px) rst = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; data_in = 8'd0; cap_en = 1'b0;
    prev_locked = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'b0, wr_en}, 0);
    check("rst_addr_data", {8'b0, wr_addr, wr_data}, 0);
    check("rst_flags", {29'b0, frame_done, locked, err}, 0);
    rst = 1'b0;

    // 1: clean frames, capture disabled; lock at the second VSYNC rise
    run_frame(V_T, -1, 0, -1, -1);
    run_frame(V_T, -1, 0, -1, -1);
    check("t1_unlocked_after_1st_rise", {31'b0, locked}, 0);
    run_frame(V_T, -1, 0, -1, -1);
    check("t1_lock_cycle", lock_cyc, start_cyc + 2);
    check("t1_locked", {31'b0, locked}, 1);
    check("t1_no_err", err_cnt, 0);
    check("t1_no_writes", wr_cnt, 0);

    // 2: full window capture
    cap_en = 1'b1;
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    check("t2_write_count", wr_cnt, N_PIX);
    check("t2_first_addr", first_addr, 0);
    check("t2_last_addr", last_addr, N_PIX - 1);
    check("t2_data_errors", bad_data, 0);
    check("t2_idle_nonzero", bad_idle, 0);
    check("t2_latency", first_wr_cyc, pix0_cyc + 2);
    check("t2_frame_done_cnt", fd_cnt, 1);
    check("t2_frame_done_cyc", fd_cyc, last_wr_cyc + 1);

    // 3: line 6 (inside the window) one clock short
    clear_stats();
    run_frame(V_T, 6, 0, -1, -1);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_writes_stop", wr_cnt, 3 * X_S);
    check("t3_no_frame_done", fd_cnt, 0);
    check("t3_unlocked", {31'b0, locked}, 0);
    check("t3_data_errors", bad_data, 0);
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    check("t3_still_unlocked", {31'b0, locked}, 0);
    check("t3_no_capture", wr_cnt, 0);
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    check("t3_relock_cycle", lock_cyc, start_cyc + 2);
    check("t3_no_capture_at_relock", wr_cnt, 0);

    // 4: frame one line short; mismatch reported at the following VSYNC rise
    clear_stats();
    run_frame(V_T - 1, -1, 0, -1, -1);
    check("t4_pre_capture", wr_cnt, N_PIX);
    check("t4_pre_no_err", err_cnt, 0);
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_err_cycle", err_cyc, start_cyc + 2);
    check("t4_no_capture", wr_cnt, 0);
    check("t4_no_frame_done", fd_cnt, 0);
    check("t4_unlocked", {31'b0, locked}, 0);

    // 5: reset for one clock in the middle of the window
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    check("t5_relocked", {31'b0, locked}, 1);
    check("t5_no_capture_relock", wr_cnt, 0);
    clear_stats();
    run_frame(V_T, -1, 0, 6, 10);
    check("t5_writes_before_rst", wr_cnt, 2 * X_S + 1);
    check("t5_no_frame_done", fd_cnt, 0);
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    run_frame(V_T, -1, 0, -1, -1);
    check("t5_no_writes_until_lock", wr_cnt, 0);
    check("t5_lock_cycle", lock_cyc, start_cyc + 2);
    check("t5_no_err", err_cnt, 0);
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    check("t5_capture_resumes", wr_cnt, N_PIX);

    // 6: single-clock enable pulse at the VSYNC rise
    cap_en = 1'b0;
    clear_stats();
    run_frame(V_T, -1, 1, -1, -1);
    check("t6_one_frame", wr_cnt, N_PIX);
    check("t6_frame_done", fd_cnt, 1);
    check("t6_data_errors", bad_data, 0);
    clear_stats();
    run_frame(V_T, -1, 0, -1, -1);
    check("t6_next_frame_none", wr_cnt, 0);
    check("t6_next_no_done", fd_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
